lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 28 ++
 rtl/lsu_ctrl.sv | 176 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Pipeline-to-LSU request/response signals and the LSU-to-data-memory port.
// The slave modport is the LSU's view; the master modport is the pipeline plus memory side.
interface lsu_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        sext_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  req_i, we_i, size_i, sext_i, addr_i, wdata_i, mem_rdata_i,
        output busy_o, done_o, err_o, rdata_o, mem_addr_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output req_i, we_i, size_i, sext_i, addr_i, wdata_i, mem_rdata_i,
        input  busy_o, done_o, err_o, rdata_o, mem_addr_o, mem_we_o, mem_wdata_o
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one access at a time against a word-wide data memory,
// with lane extraction for loads and read-modify-write for sub-word stores.
module lsu_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    lsu_ctrl_if.slave  bus
);

    // Window end is computed one bit wider so the upper bound compare cannot wrap.
    localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ACC      = 2'b01,
        MERGE_WR = 2'b10,
        RESP     = 2'b11
    } state_t;

    state_t      state_r;
    logic        we_r;
    logic [1:0]  size_r;
    logic        sext_r;
    logic [1:0]  lane_r;
    logic [15:0] wdata_r;

    logic        align_fault_s;
    logic        range_fault_s;
    logic        fault_s;
    logic [31:0] load_s;
    logic [31:0] merge_s;

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sext & b[7]}}, b};
            2'b01:   r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic half,
                                                input logic [1:0] lane, input logic [15:0] data);
        logic [31:0] r;
        r = word;
        if (half) begin
            if (lane[1]) begin
                r[31:16] = data;
            end else begin
                r[15:0] = data;
            end
        end else begin
            case (lane)
                2'b00:   r[7:0]   = data[7:0];
                2'b01:   r[15:8]  = data[7:0];
                2'b10:   r[23:16] = data[7:0];
                2'b11:   r[31:24] = data[7:0];
                default: r = word;
            endcase
        end
        return r;
    endfunction

    // Request fault classification and memory-data lane handling.
    always_comb begin
        align_fault_s = 1'b0;
        case (bus.size_i)
            2'b00:   align_fault_s = 1'b0;
            2'b01:   align_fault_s = bus.addr_i[0];
            2'b10:   align_fault_s = (bus.addr_i[1:0] != 2'b00);
            default: align_fault_s = 1'b1;
        endcase
        range_fault_s = (bus.addr_i < BASE_ADDR) || ({1'b0, bus.addr_i} >= WIN_END);
        fault_s       = align_fault_s | range_fault_s;
        load_s        = load_extract(bus.mem_rdata_i, size_r, lane_r, sext_r);
        merge_s       = store_merge(bus.mem_rdata_i, size_r[0], lane_r, wdata_r);
    end

    // Control FSM; every output is registered and cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r         <= IDLE;
            we_r            <= 1'b0;
            size_r          <= 2'b00;
            sext_r          <= 1'b0;
            lane_r          <= 2'b00;
            wdata_r         <= 16'h0000;
            bus.busy_o      <= 1'b0;
            bus.done_o      <= 1'b0;
            bus.err_o       <= 1'b0;
            bus.rdata_o     <= 32'h0000_0000;
            bus.mem_addr_o  <= 32'h0000_0000;
            bus.mem_we_o    <= 1'b0;
            bus.mem_wdata_o <= 32'h0000_0000;
        end else begin
            bus.done_o   <= 1'b0;
            bus.err_o    <= 1'b0;
            bus.mem_we_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.req_i) begin
                        we_r       <= bus.we_i;
                        size_r     <= bus.size_i;
                        sext_r     <= bus.sext_i;
                        lane_r     <= bus.addr_i[1:0];
                        wdata_r    <= bus.wdata_i[15:0];
                        bus.busy_o <= 1'b1;
                        if (fault_s) begin
                            state_r    <= RESP;
                            bus.done_o <= 1'b1;
                            bus.err_o  <= 1'b1;
                        end else begin
                            state_r        <= ACC;
                            bus.mem_addr_o <= {bus.addr_i[31:2], 2'b00};
                            if (bus.we_i && (bus.size_i == 2'b10)) begin
                                bus.mem_we_o    <= 1'b1;
                                bus.mem_wdata_o <= bus.wdata_i;
                            end else begin
                                bus.mem_we_o <= 1'b0;
                            end
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACC: begin
                    if (!we_r) begin
                        bus.rdata_o    <= load_s;
                        bus.mem_addr_o <= 32'h0000_0000;
                        bus.done_o     <= 1'b1;
                        state_r        <= RESP;
                    end else if (size_r == 2'b10) begin
                        bus.mem_addr_o <= 32'h0000_0000;
                        bus.done_o     <= 1'b1;
                        state_r        <= RESP;
                    end else begin
                        // mem_wdata_o doubles as the merge register: it captures the
                        // read word with the addressed lane already replaced.
                        bus.mem_wdata_o <= merge_s;
                        bus.mem_we_o    <= 1'b1;
                        state_r         <= MERGE_WR;
                    end
                end
                MERGE_WR: begin
                    bus.mem_addr_o <= 32'h0000_0000;
                    bus.done_o     <= 1'b1;
                    state_r        <= RESP;
                end
                RESP: begin
                    bus.busy_o <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    bus.busy_o     <= 1'b0;
                    bus.mem_addr_o <= 32'h0000_0000;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed requests push expected completions and writes,
// and a negedge monitor pops and compares whatever the DUT presents.
module tb_lsu_ctrl;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    lsu_ctrl_if bus ();

    lsu_ctrl #(
        .BASE_ADDR(32'h0000_4000),
        .MEM_BYTES(65536)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rd;
    } done_t;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    done_t dq[$];
    wr_t   wq[$];

    logic [31:0] mem [0:16383];
    logic [31:0] off;

    assign off             = bus.mem_addr_o - 32'h0000_4000;
    assign bus.mem_rdata_i = (off < 32'h0001_0000) ? mem[off[15:2]] : 32'h0000_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_we_o) mem[off[15:2]] <= bus.mem_wdata_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        done_t d;
        wr_t   w;
        if (bus.done_o) begin
            if (dq.size() == 0) begin
                n_checks++;
                $display("FAIL extra_done: got done_o=1 err_o=%b at cycle %0d expected no completion", bus.err_o, cyc);
            end else begin
                d = dq.pop_front();
                check("done_cycle", cyc, d.cyc);
                check("err", {31'b0, bus.err_o}, {31'b0, d.err});
                check("rdata", bus.rdata_o, d.rd);
            end
        end else if (bus.err_o) begin
            n_checks++;
            $display("FAIL err_without_done: got err_o=1 expected 0 at cycle %0d", cyc);
        end
        if (bus.mem_we_o) begin
            if (wq.size() == 0) begin
                n_checks++;
                $display("FAIL extra_write: got write %h to %h at cycle %0d expected none", bus.mem_wdata_o, bus.mem_addr_o, cyc);
            end else begin
                w = wq.pop_front();
                check("wr_cycle", cyc, w.cyc);
                check("wr_addr", bus.mem_addr_o, w.a);
                check("wr_data", bus.mem_wdata_o, w.d);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int lat, input logic exp_err, input logic [31:0] exp_rd,
                         input logic exp_wr, input logic [31:0] wr_a, input logic [31:0] wr_d,
                         input bit hold);
        int  acc;
        bit  idle_seen;
        done_t d;
        wr_t   w;
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.size_i  = sz;
        bus.sext_i  = sx;
        bus.addr_i  = a;
        bus.wdata_i = wd;
        @(posedge clk);
        #1;
        acc   = cyc;
        d.cyc = acc + lat - 1;
        d.err = exp_err;
        d.rd  = exp_rd;
        dq.push_back(d);
        if (exp_wr) begin
            w.cyc = acc + lat - 2;
            w.a   = wr_a;
            w.d   = wr_d;
            wq.push_back(w);
        end
        check("busy_set", {31'b0, bus.busy_o}, 32'h1);
        check("acc_addr", bus.mem_addr_o, exp_err ? 32'h0 : {a[31:2], 2'b00});
        if (hold) begin
            bus.we_i    = 1'b1;
            bus.size_i  = 2'b10;
            bus.addr_i  = 32'h0000_4010;
            bus.wdata_i = 32'hFFFF_FFFF;
        end else begin
            bus.req_i = 1'b0;
        end
        idle_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.busy_o) begin
                idle_seen = 1'b1;
                break;
            end
        end
        bus.req_i = 1'b0;
        if (!idle_seen) begin
            n_checks++;
            $display("FAIL busy_timeout: got busy_o stuck high expected idle within 20 cycles");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected completion before 100000 ns");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.size_i  = 2'b00;
        bus.sext_i  = 1'b0;
        bus.addr_i  = 32'h0;
        bus.wdata_i = 32'h0;
        #2;
        check("rst_busy", {31'b0, bus.busy_o}, 32'h0);
        check("rst_done", {31'b0, bus.done_o}, 32'h0);
        check("rst_we", {31'b0, bus.mem_we_o}, 32'h0);
        check("rst_rdata", bus.rdata_o, 32'h0);
        check("rst_maddr", bus.mem_addr_o, 32'h0);
        check("rst_wdata", bus.mem_wdata_o, 32'h0);
        #10;
        rst_n = 1'b1;
        @(negedge clk);

        //     we    sz     sx    addr          wdata         lat err  exp_rd        wr    wr_a          wr_d         hold
        issue(1'b1, 2'b10, 1'b0, 32'h0000_4010, 32'hDEAD_BEEF, 2, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_4010, 32'hDEAD_BEEF, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4010, 32'h0,        2, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0,        32'h0,        0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_4020, 32'h80FF_7F01, 2, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0000_4020, 32'h80FF_7F01, 0);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_4023, 32'h0,        2, 1'b0, 32'hFFFF_FF80, 1'b0, 32'h0,        32'h0,        0);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_4021, 32'h0,        2, 1'b0, 32'h0000_007F, 1'b0, 32'h0,        32'h0,        0);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_4022, 32'h0,        2, 1'b0, 32'hFFFF_80FF, 1'b0, 32'h0,        32'h0,        0);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_4020, 32'h0,        2, 1'b0, 32'h0000_7F01, 1'b0, 32'h0,        32'h0,        0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_4030, 32'h1122_3344, 2, 1'b0, 32'h0000_7F01, 1'b1, 32'h0000_4030, 32'h1122_3344, 0);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_4032, 32'h0000_AABB, 3, 1'b0, 32'h0000_7F01, 1'b1, 32'h0000_4030, 32'hAABB_3344, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4030, 32'h0,        2, 1'b0, 32'hAABB_3344, 1'b0, 32'h0,        32'h0,        0);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_4031, 32'h1234_5655, 3, 1'b0, 32'hAABB_3344, 1'b1, 32'h0000_4030, 32'hAABB_5544, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4030, 32'h0,        2, 1'b0, 32'hAABB_5544, 1'b0, 32'h0,        32'h0,        0);
        issue(1'b1, 2'b10, 1'b0, 32'h0001_3FFC, 32'hCAFE_F00D, 2, 1'b0, 32'hAABB_5544, 1'b1, 32'h0001_3FFC, 32'hCAFE_F00D, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h0001_3FFC, 32'h0,        2, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h0,        32'h0,        0);
        // Faulted requests: one-cycle error response, no write, rdata_o held.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0,        1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0,        32'h0,        0);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_4001, 32'h0000_1234, 1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0,        32'h0,        0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_3FFC, 32'h0,        1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0,        32'h0,        0);
        issue(1'b0, 2'b10, 1'b0, 32'h0001_4000, 32'h0,        1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0,        32'h0,        0);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_4010, 32'h0,        1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0,        32'h0,        0);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_3FFF, 32'h0000_0077, 1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0,        32'h0,        0);
        // The store held on req_i during the busy sub-word store must not have landed.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4010, 32'h0,        2, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0,        32'h0,        0);

        // Abort a sub-word store in MERGE_WR with reset.
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.size_i  = 2'b01;
        bus.sext_i  = 1'b0;
        bus.addr_i  = 32'h0000_4030;
        bus.wdata_i = 32'h0000_9999;
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        @(posedge clk);
        #1;
        check("merge_we_high", {31'b0, bus.mem_we_o}, 32'h1);
        check("merge_wdata", bus.mem_wdata_o, 32'hAABB_9999);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_we", {31'b0, bus.mem_we_o}, 32'h0);
        check("abort_busy", {31'b0, bus.busy_o}, 32'h0);
        check("abort_done", {31'b0, bus.done_o}, 32'h0);
        check("abort_rdata", bus.rdata_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4030, 32'h0,        2, 1'b0, 32'hAABB_5544, 1'b0, 32'h0,        32'h0,        0);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_4030, 32'h0000_7777, 3, 1'b0, 32'hAABB_5544, 1'b1, 32'h0000_4030, 32'hAABB_7777, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4030, 32'h0,        2, 1'b0, 32'hAABB_7777, 1'b0, 32'h0,        32'h0,        0);

        repeat (5) @(negedge clk);
        check("done_queue_empty", dq.size(), 32'h0);
        check("write_queue_empty", wq.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
